// File: rtl/mtsp_scs_issue_arbiter_if.sv
// Bus interface for the MTSP SCs issue arbiter.
// Groups the request side, the SCs primitive side and the response side of the arbiter.
//   req_valid/req_ready/req_op/req_data : per-thread request handshake (thread t at slice t)
//   sc_nen/sc_op/sc_in/sc_out           : shared SCs primitive drive and result
//   rsp_valid/rsp_ready/rsp_tid/rsp_data: in-order response stream
// slave  : arbiter view
// master : environment view (issue stage + primitive + response consumer)
interface mtsp_scs_issue_arbiter_if #(
  parameter int unsigned N_THREAD = 4,
  parameter int unsigned TID_W    = 2
);
  logic [N_THREAD-1:0]     req_valid;
  logic [N_THREAD-1:0]     req_ready;
  logic [N_THREAD*32-1:0]  req_op;
  logic [N_THREAD*128-1:0] req_data;

  logic                    sc_nen;
  logic [31:0]             sc_op;
  logic [127:0]            sc_in;
  logic [127:0]            sc_out;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [TID_W-1:0]        rsp_tid;
  logic [127:0]            rsp_data;

  modport slave (
    input  req_valid, req_op, req_data, sc_out, rsp_ready,
    output req_ready, sc_nen, sc_op, sc_in, rsp_valid, rsp_tid, rsp_data
  );

  modport master (
    output req_valid, req_op, req_data, sc_out, rsp_ready,
    input  req_ready, sc_nen, sc_op, sc_in, rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/mtsp_scs_issue_arbiter.sv
// Shares one MTSP SCs primitive between N_THREAD requesters.
// A round-robin arbiter grants at most one request per cycle, drives the primitive's registered
// nEN/OP/IN inputs, tracks each issue through a latency-matched tag pipe and returns the primitive
// result with its thread ID through a credit-protected response FIFO (issue order preserved).
// Ports:
//   i_clk   : system clock
//   i_rst   : synchronous reset, active high; discards all in-flight work
//   i_flush : stop accepting requests and drain in-flight work
//   io_bus  : request / primitive / response bus (slave modport)
//   o_idle  : nothing in flight and response FIFO empty
module mtsp_scs_issue_arbiter #(
  parameter int unsigned N_THREAD   = 4,
  parameter int unsigned SC_LATENCY = 1,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned TID_W      = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  mtsp_scs_issue_arbiter_if.slave  io_bus,
  output logic                     o_idle
);

  localparam int unsigned PtrW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned CandW = TID_W + 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [TID_W-1:0]    r_rr_ptr;
  logic [CntW-1:0]     r_credits;

  logic                w_grant_found;
  logic [TID_W-1:0]    w_grant_idx;
  logic [CandW-1:0]    w_cand;
  logic                w_issue;

  logic                r_sc_nen;
  logic [31:0]         r_sc_op;
  logic [127:0]        r_sc_in;
  logic [TID_W-1:0]    r_sc_tid;

  logic [SC_LATENCY-1:0] r_tag_v;
  logic [TID_W-1:0]      r_tag_tid [SC_LATENCY];

  logic [TID_W+127:0]  r_mem [RESP_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic                w_push;
  logic                w_pop;
  logic                w_rsp_valid;

  // Round-robin search starting at r_rr_ptr, wrapping modulo N_THREAD.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int unsigned i = 0; i < N_THREAD; i++) begin
      w_cand = {1'b0, r_rr_ptr} + CandW'(i);
      if (w_cand >= CandW'(N_THREAD)) begin
        w_cand = w_cand - CandW'(N_THREAD);
      end
      if (!w_grant_found && io_bus.req_valid[w_cand[TID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[TID_W-1:0];
      end
    end
  end

  assign w_issue = (r_state == StRun) && !i_flush && (r_credits != '0) && w_grant_found;

  always_comb begin
    io_bus.req_ready = '0;
    if (w_issue) begin
      io_bus.req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRun:   if (i_flush) w_state_nxt = StDrain;
      StDrain: if (o_idle && !i_flush) w_state_nxt = StRun;
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StRun;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_rr_ptr <= (w_grant_idx == TID_W'(N_THREAD - 1)) ? '0 : w_grant_idx + TID_W'(1);
      end
    end
  end

  // Primitive input register; OP/IN hold when nothing is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sc_nen <= 1'b1;
      r_sc_op  <= '0;
      r_sc_in  <= '0;
      r_sc_tid <= '0;
    end else begin
      r_sc_nen <= !w_issue;
      if (w_issue) begin
        r_sc_op  <= io_bus.req_op[32'(w_grant_idx) * 32 +: 32];
        r_sc_in  <= io_bus.req_data[32'(w_grant_idx) * 128 +: 128];
        r_sc_tid <= w_grant_idx;
      end
    end
  end

  assign io_bus.sc_nen = r_sc_nen;
  assign io_bus.sc_op  = r_sc_op;
  assign io_bus.sc_in  = r_sc_in;

  // Tag pipe starts at the primitive input register, so its last stage lines up with SC_OUT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_v   <= '0;
      r_tag_tid <= '{default: '0};
    end else begin
      r_tag_v[0]   <= !r_sc_nen;
      r_tag_tid[0] <= r_sc_tid;
      for (int unsigned s = 1; s < SC_LATENCY; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_tid[s] <= r_tag_tid[s-1];
      end
    end
  end

  assign w_push      = r_tag_v[SC_LATENCY-1];
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid && io_bus.rsp_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_tag_tid[SC_LATENCY-1], io_bus.sc_out};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_credits <= CntW'(RESP_DEPTH);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
      if (w_issue && !w_pop) begin
        r_credits <= r_credits - CntW'(1);
      end else if (!w_issue && w_pop) begin
        r_credits <= r_credits + CntW'(1);
      end
    end
  end

  // Outputs read as zero while empty so reset leaves no stale payload visible.
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_tid   = w_rsp_valid ? r_mem[r_rd_ptr][TID_W+127:128] : '0;
  assign io_bus.rsp_data  = w_rsp_valid ? r_mem[r_rd_ptr][127:0] : '0;

  assign o_idle = !(|r_tag_v) && r_sc_nen && (r_count == '0) &&
                  (r_credits == CntW'(RESP_DEPTH));

  // Credits bound outstanding work to the FIFO depth, so a push into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && !w_pop && (r_count == CntW'(RESP_DEPTH))));

endmodule

// File: tb/tb_mtsp_scs_issue_arbiter.sv
module tb_mtsp_scs_issue_arbiter;
  localparam int NT    = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic flush;
  logic idle;

  mtsp_scs_issue_arbiter_if #(.N_THREAD(NT), .TID_W(2)) ifc ();

  mtsp_scs_issue_arbiter #(
    .N_THREAD  (NT),
    .SC_LATENCY(LAT),
    .RESP_DEPTH(DEPTH),
    .TID_W     (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .io_bus (ifc),
    .o_idle (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy SCs primitive: X->Y->Z->W chained lanes, LAT registered stages.
  function automatic logic [127:0] sc_func(input logic [31:0] op, input logic [127:0] d);
    logic [31:0] x, y, z, w;
    x = d[127:96] + op;
    y = d[95:64] ^ x;
    z = d[63:32] + y;
    w = d[31:0] ^ {z[15:0], op[31:16]};
    return {x, y, z, w};
  endfunction

  logic [127:0] prim_pipe [LAT];
  always_ff @(posedge clk) begin
    prim_pipe[0] <= sc_func(ifc.sc_op, ifc.sc_in);
    for (int s = 1; s < LAT; s++) prim_pipe[s] <= prim_pipe[s-1];
  end
  assign ifc.sc_out = prim_pipe[LAT-1];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: every accepted request is one queue entry that becomes visible as a
  // response 2+LAT cycles after acceptance; credits are simply DEPTH minus queue size.
  typedef struct {
    logic [1:0]   tid;
    logic [127:0] data;
    int           wait_c;
  } rsp_t;

  rsp_t         m_q[$];
  int           m_rr = 0;
  bit           m_drain = 0;
  bit           m_nen = 1;
  logic [31:0]  m_sc_op = '0;
  logic [127:0] m_sc_in = '0;

  logic [3:0]   obs_ready;
  int           obs_grant;
  logic         obs_nen;
  logic         obs_rsp_valid;
  logic [1:0]   obs_tid;
  logic [127:0] obs_data;
  logic         obs_idle;
  int           obs_pops[$];

  task automatic tick();
    logic [3:0] exp_ready;
    int         g;
    bit         head_vis;
    bit         idle_now;
    rsp_t       e;
    @(negedge clk);
    g = -1;
    if (!m_drain && !flush && m_q.size() < DEPTH) begin
      for (int i = 0; i < NT; i++) begin
        if (g < 0 && ifc.req_valid[(m_rr + i) % NT]) g = (m_rr + i) % NT;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    head_vis = (m_q.size() > 0) && (m_q[0].wait_c == 0);
    idle_now = (m_q.size() == 0);

    obs_ready = ifc.req_ready;
    obs_grant = -1;
    for (int t = 0; t < NT; t++) if (obs_ready[t]) obs_grant = t;
    obs_nen       = ifc.sc_nen;
    obs_rsp_valid = ifc.rsp_valid;
    obs_tid       = ifc.rsp_tid;
    obs_data      = ifc.rsp_data;
    obs_idle      = idle;

    if (!rst) begin
      if (ifc.rsp_valid && ifc.rsp_ready) obs_pops.push_back(int'(ifc.rsp_tid));
      check("req_ready", 128'(ifc.req_ready), 128'(exp_ready));
      check("sc_nen", 128'(ifc.sc_nen), 128'(m_nen));
      check("sc_op", 128'(ifc.sc_op), 128'(m_sc_op));
      check("sc_in", ifc.sc_in, m_sc_in);
      check("rsp_valid", 128'(ifc.rsp_valid), 128'(head_vis));
      if (head_vis) begin
        check("rsp_tid", 128'(ifc.rsp_tid), 128'(m_q[0].tid));
        check("rsp_data", ifc.rsp_data, m_q[0].data);
      end
      check("idle", 128'(idle), 128'(idle_now));
    end

    if (rst) begin
      m_q.delete();
      m_rr    = 0;
      m_drain = 0;
      m_nen   = 1;
      m_sc_op = '0;
      m_sc_in = '0;
    end else begin
      if (head_vis && ifc.rsp_ready) void'(m_q.pop_front());
      for (int i = 0; i < m_q.size(); i++) begin
        if (m_q[i].wait_c > 0) begin
          e = m_q[i];
          e.wait_c--;
          m_q[i] = e;
        end
      end
      if (g >= 0) begin
        m_sc_op  = ifc.req_op[g*32 +: 32];
        m_sc_in  = ifc.req_data[g*128 +: 128];
        e.tid    = 2'(g);
        e.data   = sc_func(m_sc_op, m_sc_in);
        e.wait_c = LAT + 1;
        m_q.push_back(e);
        m_rr  = (g + 1) % NT;
        m_nen = 0;
      end else begin
        m_nen = 1;
      end
      if (!m_drain && flush) m_drain = 1;
      else if (m_drain && idle_now && !flush) m_drain = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_payload();
    for (int w = 0; w < NT; w++) ifc.req_op[w*32 +: 32] = $urandom;
    for (int w = 0; w < NT * 4; w++) ifc.req_data[w*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n_acc;
    int first_g;
    int fl_cnt;
    logic [127:0] exp_data;

    // Grant vectors applied back to back from reset (rr_ptr=0); each grant advances rr_ptr.
    vecs[0] = '{4'b0000, 4'b0000};
    vecs[1] = '{4'b0100, 4'b0100};  // rr -> 3
    vecs[2] = '{4'b0010, 4'b0010};  // search 3,0,1 wraps; rr -> 2
    vecs[3] = '{4'b1111, 4'b0100};  // rr -> 3
    vecs[4] = '{4'b1111, 4'b1000};  // rr -> 0
    vecs[5] = '{4'b1001, 4'b0001};  // rr -> 1
    vecs[6] = '{4'b1001, 4'b1000};  // rr -> 0
    vecs[7] = '{4'b0110, 4'b0010};  // rr -> 2
    vecs[8] = '{4'b0000, 4'b0000};

    rst = 1'b1;
    flush = 1'b0;
    ifc.req_valid = '0;
    ifc.req_op = '0;
    ifc.req_data = '0;
    ifc.rsp_ready = 1'b1;
    do_reset();
    do_reset();

    // Reset state
    tick();
    check("reset_ready", 128'(obs_ready), 128'(0));
    check("reset_nen", 128'(obs_nen), 128'(1));
    check("reset_rsp_valid", 128'(obs_rsp_valid), 128'(0));
    check("reset_idle", 128'(obs_idle), 128'(1));

    for (int v = 0; v < 9; v++) begin
      ifc.req_valid = vecs[v].valid;
      rand_payload();
      tick();
      check($sformatf("vec%0d_ready", v), 128'(obs_ready), 128'(vecs[v].exp_ready));
    end
    for (int i = 0; i < 6; i++) tick();

    // Single request from thread 2 through the full latency.
    do_reset();
    ifc.req_valid = 4'b0100;
    ifc.req_op[2*32 +: 32] = 32'h0000_4444;
    ifc.req_data[2*128 +: 128] = {32'd1, 32'd2, 32'd3, 32'd4};
    exp_data = sc_func(32'h0000_4444, {32'd1, 32'd2, 32'd3, 32'd4});
    tick();
    check("t1_ready", 128'(obs_ready), 128'(4'b0100));
    ifc.req_valid = '0;
    tick();
    check("t1_nen", 128'(obs_nen), 128'(0));
    tick();
    check("t1_rsp_early", 128'(obs_rsp_valid), 128'(0));
    tick();
    check("t1_rsp_valid", 128'(obs_rsp_valid), 128'(1));
    check("t1_rsp_tid", 128'(obs_tid), 128'(2));
    check("t1_rsp_data", obs_data, exp_data);

    // All threads continuously valid: grants rotate, responses follow issue order.
    do_reset();
    obs_pops.delete();
    ifc.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      rand_payload();
      tick();
      check("t2_grant", 128'(obs_grant), 128'(i % 4));
    end
    ifc.req_valid = '0;
    for (int i = 0; i < 8; i++) tick();
    check("t2_pop_count", 128'(obs_pops.size()), 128'(6));
    for (int i = 0; i < 6 && i < obs_pops.size(); i++) begin
      check("t2_pop_order", 128'(obs_pops[i]), 128'(i % 4));
    end

    // Credit exhaustion with a stalled consumer.
    do_reset();
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'b1111;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_grant >= 0) n_acc++;
    end
    check("t3_accepts", 128'(n_acc), 128'(4));
    check("t3_stalled_ready", 128'(obs_ready), 128'(0));
    ifc.rsp_ready = 1'b1;
    n_acc = 0;
    first_g = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      ifc.rsp_ready = 1'b0;
      if (obs_grant >= 0) begin
        n_acc++;
        if (first_g < 0) first_g = obs_grant;
      end
    end
    check("t3_one_grant", 128'(n_acc), 128'(1));
    check("t3_grant_thread", 128'(first_g), 128'(0));
    ifc.req_valid = '0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Flush with two requests in flight.
    do_reset();
    obs_pops.delete();
    ifc.req_valid = 4'b0011;
    tick();
    tick();
    ifc.req_valid = 4'b1111;
    flush = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_grant >= 0) n_acc++;
    end
    check("t4_no_grant", 128'(n_acc), 128'(0));
    check("t4_pops", 128'(obs_pops.size()), 128'(2));
    check("t4_idle", 128'(obs_idle), 128'(1));
    flush = 1'b0;
    tick();
    check("t4_drain_exit_ready", 128'(obs_ready), 128'(0));
    tick();
    check("t4_resume_ready", 128'(obs_ready), 128'(4'b0100));
    ifc.req_valid = '0;
    for (int i = 0; i < 6; i++) tick();

    // Reset with three requests in flight.
    do_reset();
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    ifc.req_valid = '0;
    do_reset();
    tick();
    check("t5_rsp_valid", 128'(obs_rsp_valid), 128'(0));
    check("t5_nen", 128'(obs_nen), 128'(1));
    check("t5_idle", 128'(obs_idle), 128'(1));
    check("t5_rsp_tid", 128'(obs_tid), 128'(0));
    check("t5_rsp_data", obs_data, 128'(0));
    ifc.rsp_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_rsp_valid) n_acc++;
    end
    check("t5_no_stale", 128'(n_acc), 128'(0));

    // Randomized traffic against the reference model.
    fl_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      ifc.req_valid = 4'($urandom);
      ifc.rsp_ready = ($urandom % 4) != 0;
      rand_payload();
      if (fl_cnt > 0) fl_cnt--;
      else if ($urandom % 64 == 0) fl_cnt = int'($urandom_range(1, 12));
      flush = (fl_cnt > 0);
      rst = ($urandom % 400 == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    ifc.req_valid = '0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("final_idle", 128'(obs_idle), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
